// File: rtl/mux_scan_pkg.sv
// Shared types and limits for the mux scan capture block.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int NCH        = 4;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

endpackage

// File: rtl/mux_scan_timer.sv
// Settle counter: counts while en is high, done pulses on the last cycle of each SETTLE window.
// Latency: done is combinational from the counter; backpressure: none, counter clears whenever en is low.
module mux_scan_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  assign done = en && (cnt == CNT_W'(SETTLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_capture.sv
// Steps sel through 4 mux inputs, samples q_in after SETTLE cycles each; word/valid after 4*SETTLE edges.
// Holds word until valid&&ready; define MUX_SCAN_CONT_EN to rescan immediately after each handshake.
module mux_scan_capture
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [1:0]     sel,
  input  logic           q_in,
  output logic [NCH-1:0] word,
  output logic           valid,
  input  logic           ready,
  output logic           busy
);

  state_t         state;
  logic [NCH-1:0] shadow;
  logic [NCH-1:0] shadow_nxt;
  logic           scan_en;
  logic           cap;

  assign scan_en = (state == SCAN);
  assign busy    = (state != IDLE);

  mux_scan_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (scan_en),
    .done (cap)
  );

  // The final channel goes straight into word alongside the earlier shadow bits.
  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[sel] = q_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      shadow <= '0;
      word   <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            sel   <= '0;
          end
        end
        SCAN: begin
          if (cap) begin
            shadow <= shadow_nxt;
            if (sel == 2'(NCH - 1)) begin
              word  <= shadow_nxt;
              valid <= 1'b1;
              state <= HOLD;
            end else begin
              sel <= sel + 2'd1;
            end
          end
        end
        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            sel   <= '0;
`ifdef MUX_SCAN_CONT_EN
            state <= SCAN;
`else
            state <= IDLE;
`endif
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench for mux_scan_capture with a 4:1 mux model and an expected-word queue.
module tb_mux_scan_capture;

  localparam int S_A = 2;
  localparam int S_B = 1;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b;
  logic [1:0] sel_a, sel_b;
  logic       q_a, q_b;
  logic [3:0] word_a, word_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       busy_a, busy_b;
  logic [3:0] d_a, d_b;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  assign q_a = d_a[sel_a];
  assign q_b = d_b[sel_b];

  mux_scan_capture #(.SETTLE(S_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .sel(sel_a), .q_in(q_a),
    .word(word_a), .valid(valid_a), .ready(ready_a), .busy(busy_a)
  );

  mux_scan_capture #(.SETTLE(S_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .sel(sel_b), .q_in(q_b),
    .word(word_b), .valid(valid_b), .ready(ready_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_word(input string tag, input logic [3:0] obs);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // Called at a negedge. restart_k: edge index at which start is re-pulsed.
  // abort_k: negedge index after which reset is pulsed asynchronously.
  task automatic scan_a(input logic [3:0] d, input int restart_k, input int abort_k);
    int lat;
    int es;
    lat = 0;
    d_a = d;
    start_a = 1'b1;
    exp_q.push_back(d);
    @(negedge clk);
    chk("busy_after_start", busy_a, 1);
    chk("sel_at_start", sel_a, 0);
    for (int k = 1; k <= 40; k++) begin
      start_a = (k == restart_k);
      @(negedge clk);
      if (k == abort_k) begin
        start_a = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_sel", sel_a, 0);
        chk("rst_mid_valid", valid_a, 0);
        chk("rst_mid_word", word_a, 0);
        chk("rst_mid_busy", busy_a, 0);
        #1 rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("first_edge_after_rst_idle", busy_a, 0);
        return;
      end
      es = k / S_A;
      if (es > 3) es = 3;
      chk("sel_step", sel_a, es);
      if (valid_a) begin
        lat = k;
        break;
      end
    end
    start_a = 1'b0;
    chk("latency", lat, 4 * S_A);
    pop_word("word", word_a);
  endtask

  initial begin
    int lat;
    int t, last, np;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0;
    d_a = 4'b0000; d_b = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_sel", sel_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_word", word_a, 0);
    chk("rst_b_valid", valid_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", busy_a, 0);

`ifndef MUX_SCAN_CONT_EN
    // Basic scan with consumer ready on HOLD entry
    ready_a = 1'b1;
    scan_a(4'b0110, -1, -1);
    @(negedge clk);
    chk("valid_drop", valid_a, 0);
    chk("idle_after_xfer", busy_a, 0);
    chk("sel_idle", sel_a, 0);
    @(negedge clk);
    chk("no_restart", busy_a, 0);
    chk("word_kept_idle", word_a, 4'b0110);

    // Consumer stalls for 5 cycles
    ready_a = 1'b0;
    scan_a(4'b1001, -1, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", valid_a, 1);
      chk("hold_word", word_a, 4'b1001);
    end
    ready_a = 1'b1;
    @(negedge clk);
    chk("hold_release", valid_a, 0);

    // start re-pulsed while sel==1
    scan_a(4'b0011, 3, -1);
    @(negedge clk);
    chk("restart_valid_drop", valid_a, 0);

    // Async reset at sel==2, then a clean scan
    scan_a(4'b0101, -1, 4);
    scan_a(4'b1110, -1, -1);
    @(negedge clk);
    chk("post_rst_drop", valid_a, 0);

    // SETTLE=1 with input changing mid-scan
    ready_b = 1'b1;
    d_b = 4'b0000;
    start_b = 1'b1;
    exp_q.push_back(4'b1100);
    @(negedge clk);
    start_b = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sel_b == 2'd2) d_b = 4'b1111;
      if (valid_b) begin
        lat = k;
        break;
      end
    end
    chk("b_latency", lat, 4 * S_B);
    pop_word("b_word", word_b);
    @(negedge clk);
    chk("b_valid_drop", valid_b, 0);
`else
    // Continuous mode: one start, then back-to-back scans
    ready_a = 1'b1;
    d_a = 4'b0101;
    start_a = 1'b1;
    exp_q.push_back(4'b0101);
    @(negedge clk);
    start_a = 1'b0;
    t = 0; last = 0; np = 0;
    while (np < 3 && t < 200) begin
      @(negedge clk);
      t++;
      if (valid_a) begin
        chk("cont_interval", t - last, (np == 0) ? 4 * S_A : 4 * S_A + 1);
        pop_word("cont_word", word_a);
        exp_q.push_back(4'b0101);
        last = t;
        np++;
        @(negedge clk);
        t++;
        chk("cont_valid_drop", valid_a, 0);
        chk("cont_busy", busy_a, 1);
      end
    end
    chk("cont_pulses", np, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_capture.md
MUX_SCAN_CAPTURE -- requirements
Module: mux_scan_capture

Interface
REQ-001 Parameter SETTLE, default 2, clk cycles each select value is held before q is sampled; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a 4-channel scan.
REQ-005 sel  output  2  select driven to the downstream 4:1 mux.
REQ-006 q_in  input  1  mux output fed back for sampling.
REQ-007 word  output  4  captured word; word[i] holds q_in sampled while sel==i.
REQ-008 valid  output  1  word is complete and stable.
REQ-009 ready  input  1  consumer accepts word.
REQ-010 busy  output  1  high in SCAN and HOLD.

Function
REQ-011 FSM states SHALL be IDLE, SCAN and HOLD.
REQ-012 IDLE: sel=0, valid=0, busy=0; start=1 at an edge -> SCAN with sel=0 and settle counter=0.
REQ-013 SCAN: counter increments each edge; at the edge where counter==SETTLE-1, q_in is captured into shadow bit [sel] and counter clears.
REQ-014 SCAN, capture with sel<3: sel increments by 1 at the same edge.
REQ-015 SCAN, capture with sel==3: word <= complete shadow value, valid=1, state -> HOLD, and sel stays 3.
REQ-016 Latency: valid rises exactly 4*SETTLE edges after the edge that accepted start.
REQ-017 HOLD: word and valid are stable until valid&&ready at an edge; then valid=0 and state -> IDLE.
REQ-018 ready is ignored outside HOLD; ready already high on HOLD entry completes the transfer at the next edge.
REQ-019 start is ignored while busy=1, with no restart and no counter disturbance.
REQ-020 word holds its last captured value in IDLE; only a completed scan updates it.
REQ-021 sel is a registered output and changes only at clock edges.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, sel=0, counter=0, shadow=0, word=4'b0000, valid=0 and busy=0, including mid-scan and mid-HOLD.
REQ-023 The first edge after rst_n deasserts SHALL behave as IDLE.

Configuration
REQ-024 Macro MUX_SCAN_CONT_EN defined: a valid&&ready handshake moves directly to SCAN with sel=0 and no start needed; leaving IDLE still requires start.
REQ-025 MUX_SCAN_CONT_EN undefined: the handshake returns to IDLE, as in REQ-017.

Structure
REQ-026 Package mux_scan_pkg SHALL hold the state enum typedef (IDLE/SCAN/HOLD), NCH=4, and the SETTLE range limit 15.
REQ-027 Sub-module mux_scan_timer (the settle counter with done pulse) is natural; all other logic stays in one module.

Verification
REQ-028 Mux d=4'b0110, SETTLE=2, start pulse, ready=1 -> sel steps 0,1,2,3 every 2 cycles; valid is high 8 edges after start with word=4'b0110; valid drops on the next edge.
REQ-029 d=4'b1001, ready=0 for 5 cycles after valid -> word stays 4'b1001 and valid stays 1 throughout; transfer completes on the edge where ready=1.
REQ-030 start re-pulsed at sel=1 mid-scan -> scan timing unchanged; valid still at 8 edges after the first start.
REQ-031 rst_n asserted at sel=2 mid-scan -> sel=0, valid=0, word=0 with no clock; next start gives a full correct scan.
REQ-032 SETTLE=1, d changing 0000->1111 after sel=1 is captured -> word=4'b1100.
REQ-033 MUX_SCAN_CONT_EN defined, ready tied 1, d=4'b0101 -> valid pulses every 4*SETTLE+1 edges, each with word=4'b0101.
